// File: rtl/resource_value_if.sv
// ============================================================================
// resource_value_if : start/bitmap/result bundle between field and resource_value
// Optional max_value signal present when RESOURCE_MAX_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface resource_value_if #(
    parameter int W  = 50,
    parameter int H  = 50,
    parameter int CW = 12
);
    logic              start;
    logic [W*H-1:0]    trees;
    logic [W*H-1:0]    lumberyards;
    logic              busy;
    logic              done;
    logic [CW-1:0]     tree_count;
    logic [CW-1:0]     lumber_count;
    logic [2*CW-1:0]   value;
    logic              conflict;
`ifdef RESOURCE_MAX_EN
    logic [2*CW-1:0]   max_value;
`endif

    modport master (
        output start, trees, lumberyards,
        input  busy, done, tree_count, lumber_count, value, conflict
`ifdef RESOURCE_MAX_EN
        , input max_value
`endif
    );

    modport slave (
        input  start, trees, lumberyards,
        output busy, done, tree_count, lumber_count, value, conflict
`ifdef RESOURCE_MAX_EN
        , output max_value
`endif
    );
endinterface

`default_nettype wire

// File: rtl/resource_value.sv
// ============================================================================
// resource_value : row-serial tree/lumberyard count of a captured grid snapshot
// and their product. RESOURCE_MAX_EN adds a running max_value output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module resource_value #(
    parameter int W  = 50,
    parameter int H  = 50,
    parameter int CW = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    resource_value_if.slave   bus
);
    localparam int N  = W * H;
    localparam int RW = $clog2(H + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [N-1:0]     r_snap_t;
    logic [N-1:0]     r_snap_l;
    logic [RW-1:0]    r_row;
    logic             r_pipe_vld;
    logic [CW-1:0]    r_pipe_t;
    logic [CW-1:0]    r_pipe_l;
    logic             r_pipe_c;
    logic [CW-1:0]    r_acc_t;
    logic [CW-1:0]    r_acc_l;
    logic             r_acc_c;
    logic [CW-1:0]    r_tree_count;
    logic [CW-1:0]    r_lumber_count;
    logic [2*CW-1:0]  r_value;
    logic             r_conflict;
    logic [W-1:0]     w_only_t;
    logic [W-1:0]     w_only_l;
    logic [W-1:0]     w_both;
    logic             w_last;

    function automatic logic [CW-1:0] popcount(input logic [W-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++)
            n = n + {{(CW-1){1'b0}}, bits[i]};
        return n;
    endfunction

    // Snapshot is shifted down one row per cycle so the current row is always the low W bits.
    assign w_only_t = r_snap_t[W-1:0] & ~r_snap_l[W-1:0];
    assign w_only_l = r_snap_l[W-1:0] & ~r_snap_t[W-1:0];
    assign w_both   = r_snap_t[W-1:0] &  r_snap_l[W-1:0];
    assign w_last   = (r_row == RW'(H));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_COUNT;
            S_COUNT: if (w_last)    w_next = S_MUL;
            S_MUL:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_COUNT, S_MUL: bus.busy = 1'b1;
            S_DONE:         bus.done = 1'b1;
            default: ;
        endcase
    end

    // Row popcounts are registered before accumulation; the extra row slot (row == H) drains that stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_t       <= '0;
            r_snap_l       <= '0;
            r_row          <= '0;
            r_pipe_vld     <= 1'b0;
            r_pipe_t       <= '0;
            r_pipe_l       <= '0;
            r_pipe_c       <= 1'b0;
            r_acc_t        <= '0;
            r_acc_l        <= '0;
            r_acc_c        <= 1'b0;
            r_tree_count   <= '0;
            r_lumber_count <= '0;
            r_value        <= '0;
            r_conflict     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pipe_vld <= 1'b0;
                    if (bus.start) begin
                        r_snap_t <= bus.trees;
                        r_snap_l <= bus.lumberyards;
                        r_row    <= '0;
                        r_acc_t  <= '0;
                        r_acc_l  <= '0;
                        r_acc_c  <= 1'b0;
                    end
                end
                S_COUNT: begin
                    r_snap_t   <= r_snap_t >> W;
                    r_snap_l   <= r_snap_l >> W;
                    r_row      <= w_last ? r_row : r_row + 1'b1;
                    r_pipe_vld <= !w_last;
                    r_pipe_t   <= popcount(w_only_t);
                    r_pipe_l   <= popcount(w_only_l);
                    r_pipe_c   <= |w_both;
                    if (r_pipe_vld) begin
                        r_acc_t <= r_acc_t + r_pipe_t;
                        r_acc_l <= r_acc_l + r_pipe_l;
                        r_acc_c <= r_acc_c | r_pipe_c;
                    end
                end
                S_MUL: begin
                    r_pipe_vld     <= 1'b0;
                    r_tree_count   <= r_acc_t;
                    r_lumber_count <= r_acc_l;
                    r_conflict     <= r_acc_c;
                    r_value        <= (2*CW)'(r_acc_t) * (2*CW)'(r_acc_l);
                end
                default: r_pipe_vld <= 1'b0;
            endcase
        end
    end

    assign bus.tree_count   = r_tree_count;
    assign bus.lumber_count = r_lumber_count;
    assign bus.value        = r_value;
    assign bus.conflict     = r_conflict;

`ifdef RESOURCE_MAX_EN
    logic [2*CW-1:0] r_max_value;

    always_ff @(posedge clk) begin
        if (rst)
            r_max_value <= '0;
        else if (r_state == S_DONE && r_value > r_max_value)
            r_max_value <= r_value;
    end

    assign bus.max_value = r_max_value;
`endif

endmodule

`default_nettype wire

// File: tb/tb_resource_value.sv
// ============================================================================
// tb_resource_value : directed checks of resource_value on 50x50 and 10x10 grids
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_resource_value;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   busy_cyc;
    int   pulses;
    int   done_cyc;
    byte  ch;
    string grid [10];

    resource_value_if #(.W(50), .H(50), .CW(12)) b50 ();
    resource_value_if #(.W(10), .H(10), .CW(12)) b10 ();

    resource_value #(.W(50), .H(50), .CW(12)) dut50 (.clk(clk), .rst(rst), .bus(b50));
    resource_value #(.W(10), .H(10), .CW(12)) dut10 (.clk(clk), .rst(rst), .bus(b10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run50(output int c, output int bc);
        b50.start = 1'b1;
        @(negedge clk);
        b50.start = 1'b0;
        c  = 1;
        bc = b50.busy ? 1 : 0;
        while (!b50.done && c < 200) begin
            @(negedge clk);
            c++;
            if (b50.busy) bc++;
        end
    endtask

    task automatic run10(output int c, output int bc);
        b10.start = 1'b1;
        @(negedge clk);
        b10.start = 1'b0;
        c  = 1;
        bc = b10.busy ? 1 : 0;
        while (!b10.done && c < 200) begin
            @(negedge clk);
            c++;
            if (b10.busy) bc++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        grid = '{".||##.....", "||###.....", "||##......", "|##.....##", "|##.....##",
                 "|##....##|", "||##.####|", "||#####|||", "||||#|||||", "||||||||||"};
        rst = 1'b1;
        b50.start = 1'b0; b50.trees = '0; b50.lumberyards = '0;
        b10.start = 1'b0; b10.trees = '0; b10.lumberyards = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("reset_busy", 64'(b50.busy), 0);
        check("reset_done", 64'(b50.done), 0);
        check("reset_counts", 64'({b50.tree_count, b50.lumber_count}), 0);
        check("reset_value", 64'(b50.value), 0);
        check("reset_conflict", 64'(b50.conflict), 0);

        // all-zero bitmaps: latency and busy width
        run50(cyc, busy_cyc);
        check("zero_latency", 64'(cyc), 53);
        check("zero_busy_cycles", 64'(busy_cyc), 52);
        check("zero_value", 64'(b50.value), 0);
        check("zero_conflict", 64'(b50.conflict), 0);
        @(negedge clk);
        check("done_single_cycle", 64'(b50.done), 0);

        // all trees
        b50.trees = '1;
        run50(cyc, busy_cyc);
        check("alltrees_tree", 64'(b50.tree_count), 2500);
        check("alltrees_lumber", 64'(b50.lumber_count), 0);
        check("alltrees_value", 64'(b50.value), 0);
        @(negedge clk);

        // conflict cell excluded from both counts
        b50.trees = '0; b50.lumberyards = '0;
        b50.trees[0] = 1'b1; b50.trees[1] = 1'b1;
        b50.lumberyards[0] = 1'b1; b50.lumberyards[2] = 1'b1;
        run50(cyc, busy_cyc);
        check("conf_tree", 64'(b50.tree_count), 1);
        check("conf_lumber", 64'(b50.lumber_count), 1);
        check("conf_value", 64'(b50.value), 1);
        check("conf_flag", 64'(b50.conflict), 1);
        @(negedge clk);

        // restarts during busy/done ignored, inputs flipped after capture
        b50.trees = '0; b50.lumberyards = '0;
        for (int i = 0; i < 10; i++) b50.trees[i] = 1'b1;
        for (int i = 100; i < 105; i++) b50.lumberyards[i] = 1'b1;
        b50.start = 1'b1;
        @(negedge clk);
        b50.start = 1'b0;
        cyc = 1; pulses = 0; done_cyc = 0;
        b50.trees = '1; b50.lumberyards = '0;
        while (cyc < 120) begin
            if (b50.start) b50.start = 1'b0;
            if (cyc == 5) b50.start = 1'b1;
            if (cyc == 10) check("hold_mid_run", 64'(b50.tree_count), 1);
            if (b50.done) begin
                pulses++;
                if (pulses == 1) begin
                    done_cyc = cyc;
                    b50.start = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("restart_pulses", 64'(pulses), 1);
        check("restart_latency", 64'(done_cyc), 53);
        check("flip_tree", 64'(b50.tree_count), 10);
        check("flip_lumber", 64'(b50.lumber_count), 5);
        check("flip_value", 64'(b50.value), 50);

        // reset in the middle of counting row 20
        b50.trees = '1; b50.lumberyards = '0;
        b50.start = 1'b1;
        @(negedge clk);
        b50.start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(b50.busy), 0);
        check("abort_outputs", 64'({b50.tree_count, b50.lumber_count, b50.value, b50.conflict}), 0);
        b50.trees = '0; b50.lumberyards = '0;
        for (int i = 0; i < 7; i++) b50.trees[i] = 1'b1;
        for (int i = 2490; i < 2493; i++) b50.lumberyards[i] = 1'b1;
        run50(cyc, busy_cyc);
        check("after_abort_latency", 64'(cyc), 53);
        check("after_abort_value", 64'(b50.value), 21);
        check("after_abort_counts", 64'({b50.tree_count, b50.lumber_count}), 64'({12'd7, 12'd3}));
        @(negedge clk);

        // 10x10 example grid
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                ch = grid[i][j];
                b10.trees[i*10+j]       = (ch == 8'h7C);
                b10.lumberyards[i*10+j] = (ch == 8'h23);
            end
        end
        run10(cyc, busy_cyc);
        check("grid10_latency", 64'(cyc), 13);
        check("grid10_busy_cycles", 64'(busy_cyc), 12);
        check("grid10_tree", 64'(b10.tree_count), 37);
        check("grid10_lumber", 64'(b10.lumber_count), 31);
        check("grid10_value", 64'(b10.value), 1147);
        check("grid10_conflict", 64'(b10.conflict), 0);
        @(negedge clk);
`ifdef RESOURCE_MAX_EN
        check("max_first", 64'(b10.max_value), 1147);
        b10.trees = '0; b10.lumberyards = '0;
        run10(cyc, busy_cyc);
        check("max_zero_value", 64'(b10.value), 0);
        @(negedge clk);
        check("max_kept", 64'(b10.max_value), 1147);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
